nested_expr_evaluator: RTL

- Sequential evaluator for a token stream describing fully parenthesized 8-bit integer expressions, e.g. (((a + b) * c) - d).
- Consumes one token per cycle over a valid/ready handshake and keeps nesting context on an internal stack.
- Presents the 8-bit result and an error code over a second valid/ready handshake.
- Serves as the runtime consumer of the expression forms the front end emits, and as a golden checker against the combinational expression tests.

---
 rtl/nested_expr_evaluator.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/nested_expr_evaluator.sv
// Token-stream evaluator for fully parenthesized expressions with strict left-to-right evaluation.
// Open parentheses save the enclosing level's {acc, pend_op, have_acc} on a small stack.
module nested_expr_evaluator #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tok_valid,
  output logic                         tok_ready,
  input  logic [2:0]                   tok_kind,
  input  logic [WIDTH-1:0]             tok_data,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [WIDTH-1:0]             res_data,
  output logic [2:0]                   res_err,
  output logic [$clog2(DEPTH+1)-1:0]   depth
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] K_NUM = 3'd0;
  localparam logic [2:0] K_OP  = 3'd1;
  localparam logic [2:0] K_LP  = 3'd2;
  localparam logic [2:0] K_RP  = 3'd3;
  localparam logic [2:0] K_END = 3'd4;

  typedef enum logic [1:0] {EXP_OPND, EXP_OPTR, DONE, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [2:0]        pend_op_q, pend_op_d;
  logic              have_acc_q, have_acc_d;
  logic [WIDTH-1:0]  res_data_q, res_data_d;
  logic [2:0]        res_err_q, res_err_d;
  logic [WIDTH-1:0]  stk_acc_q [DEPTH];
  logic [WIDTH-1:0]  stk_acc_d [DEPTH];
  logic [2:0]        stk_op_q [DEPTH];
  logic [2:0]        stk_op_d [DEPTH];
  logic              stk_have_q [DEPTH];
  logic              stk_have_d [DEPTH];

  logic              tok_fire;
  logic [AW-1:0]     push_idx, pop_idx;

  function automatic logic [WIDTH-1:0] alu(input logic [2:0] op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a * b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      3'd6:    return a << b[2:0];
      default: return a >> b[2:0];
    endcase
  endfunction

  assign tok_ready = (state_q != DONE);
  assign res_valid = (state_q == DONE);
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign depth     = depth_q;
  assign tok_fire  = tok_valid && tok_ready;
  assign push_idx  = AW'(depth_q);
  assign pop_idx   = AW'(depth_q - DW'(1));

  always_comb begin
    state_d    = state_q;
    depth_d    = depth_q;
    acc_d      = acc_q;
    pend_op_d  = pend_op_q;
    have_acc_d = have_acc_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    stk_acc_d  = stk_acc_q;
    stk_op_d   = stk_op_q;
    stk_have_d = stk_have_q;

    case (state_q)
      EXP_OPND: if (tok_fire) begin
        case (tok_kind)
          K_NUM: begin
            acc_d      = have_acc_q ? alu(pend_op_q, acc_q, tok_data) : tok_data;
            have_acc_d = 1'b1;
            state_d    = EXP_OPTR;
          end
          K_LP: begin
            if (depth_q == DW'(DEPTH)) begin
              res_err_d = 3'd2;
              state_d   = DRAIN;
            end else begin
              stk_acc_d[push_idx]  = acc_q;
              stk_op_d[push_idx]   = pend_op_q;
              stk_have_d[push_idx] = have_acc_q;
              have_acc_d           = 1'b0;
              depth_d              = depth_q + DW'(1);
            end
          end
          // An END here has already closed the stream, so there is nothing left to drain.
          K_END: begin
            res_err_d  = 3'd1;
            res_data_d = '0;
            state_d    = DONE;
          end
          default: begin
            res_err_d = 3'd1;
            state_d   = DRAIN;
          end
        endcase
      end
      EXP_OPTR: if (tok_fire) begin
        case (tok_kind)
          K_OP: begin
            if (tok_data[3]) begin
              res_err_d = 3'd5;
              state_d   = DRAIN;
            end else begin
              pend_op_d = tok_data[2:0];
              state_d   = EXP_OPND;
            end
          end
          K_RP: begin
            if (depth_q == '0) begin
              res_err_d = 3'd3;
              state_d   = DRAIN;
            end else begin
              acc_d      = stk_have_q[pop_idx] ?
                           alu(stk_op_q[pop_idx], stk_acc_q[pop_idx], acc_q) : acc_q;
              pend_op_d  = stk_op_q[pop_idx];
              have_acc_d = 1'b1;
              depth_d    = depth_q - DW'(1);
            end
          end
          K_END: begin
            res_err_d  = (depth_q != '0) ? 3'd4 : 3'd0;
            res_data_d = (depth_q != '0) ? '0 : acc_q;
            state_d    = DONE;
          end
          default: begin
            res_err_d = 3'd1;
            state_d   = DRAIN;
          end
        endcase
      end
      DRAIN: if (tok_fire && tok_kind == K_END) begin
        res_data_d = '0;
        state_d    = DONE;
      end
      default: if (res_ready) begin
        state_d    = EXP_OPND;
        depth_d    = '0;
        acc_d      = '0;
        pend_op_d  = '0;
        have_acc_d = 1'b0;
        res_data_d = '0;
        res_err_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EXP_OPND;
      depth_q    <= '0;
      acc_q      <= '0;
      pend_op_q  <= '0;
      have_acc_q <= 1'b0;
      res_data_q <= '0;
      res_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      depth_q    <= depth_d;
      acc_q      <= acc_d;
      pend_op_q  <= pend_op_d;
      have_acc_q <= have_acc_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
    stk_acc_q  <= stk_acc_d;
    stk_op_q   <= stk_op_d;
    stk_have_q <= stk_have_d;
  end

endmodule
